hdl_watchdog_timer: RTL
=======================

Name: hdl_watchdog_timer

Overview:
- HDL-side end of the truss watchdog interface.
- The verification side writes a timeout count (hdl_timeout_count_); this block counts it down in simulation time and drives hdl_timeout_ back when the budget expires.
- Sits in the testbench top, next to the DUT, one instance per watchdog.
- Adds a prescaler, a kick (heartbeat) reload, and a readable remaining count, so the verification side can pet the watchdog or poll it.

Parameters:
- COUNTER_WIDTH, 32, width of the timeout count and the down-counter.
- PRESCALE_WIDTH, 8, width of the prescale divider field.

Ports:
- clk  input  1  single testbench clock; all state on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- hdl_timeout_count_  input  COUNTER_WIDTH  timeout budget written by the verification side, in prescaled ticks.
- load  input  1  one-cycle strobe; captures hdl_timeout_count_ and prescale.
- prescale  input  PRESCALE_WIDTH  clocks per tick minus one (0 = every clock).
- kick  input  1  reloads the counter from the last captured budget.
- clear  input  1  drops hdl_timeout_ and returns the block to IDLE.
- hdl_timeout_  output  1  watchdog expired; sticky.
- armed  output  1  counter running.
- remaining  output  COUNTER_WIDTH  current down-counter value.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the bench):
  - hdl_timeout_=0, armed=0, remaining=0.
  - Captured budget=0, captured prescale=0, prescale counter=0.
  - State IDLE.
- States: IDLE, ARMED, EXPIRED.
- Load, in any state:
  - Captures budget B=hdl_timeout_count_ and prescale P.
  - Sets remaining=B and prescale counter=P.
  - Clears hdl_timeout_.
  - If B!=0, goes to ARMED; if B==0, goes to IDLE (B=0 disarms).
  - Effects are visible the cycle after the load edge.
- ARMED:
  - Prescale counter decrements each clk.
  - When the prescale counter is 0 it reloads to P and remaining decrements (one tick).
  - When a tick takes remaining from 1 to 0, the same edge sets hdl_timeout_=1, clears armed and goes to EXPIRED.
  - Latency with P=0: load at edge t, hdl_timeout_ high after edge t+B. In general after edge t+B*(P+1).
- Kick:
  - In ARMED: remaining=B and prescale counter=P.
  - In IDLE or EXPIRED: ignored; kick never re-arms an expired watchdog.
- Clear: hdl_timeout_=0, armed=0, remaining=0, state IDLE. The captured B and P are retained.
- EXPIRED: hdl_timeout_ holds 1, remaining holds 0, until load, clear or reset.
- Priority for simultaneous strobes: reset > load > clear > kick > tick.
  - Load with clear: load wins.
  - Kick on the expiry edge: the kick wins, remaining reloads and hdl_timeout_ stays 0.
- Arithmetic:
  - Unsigned.
  - remaining never wraps below 0.
  - B = all-ones is legal; no overflow is possible because the counter only decrements.
- armed == (state==ARMED).
- Reset mid-count: returns to the reset values immediately (asynchronous). A pending expiry is lost.

Test Plan:
- Basic expiry: reset_n low 2 clk, release; load B=10, P=0 at cycle 5 -> armed=1 from cycle 6, remaining 10..1, hdl_timeout_=1 after edge 15 and sticky for 50 clk.
- Prescale: load B=4, P=3 -> remaining decrements every 4 clk; hdl_timeout_ after 16 clk; armed=0 afterwards.
- Kick:
  - Load B=8, P=0, kick every 5 clk for 100 clk -> hdl_timeout_ never asserts.
  - Stop kicking -> asserts 8 clk after the last kick.
  - Kick on the expiry edge -> no timeout.
- Zero and re-arm:
  - Load B=0 -> stays IDLE with hdl_timeout_=0.
  - In EXPIRED, assert kick -> still EXPIRED.
  - Load B=3 -> hdl_timeout_ drops next cycle, re-expires 3 clk later.
- Clear/load collision: in ARMED with remaining=5, assert clear and load(B=7) in the same cycle -> ARMED, remaining=7.
  - Clear alone -> IDLE, remaining=0, hdl_timeout_=0.
- Async reset: load B=all-ones, run 20 clk, pulse reset_n low mid-cycle -> outputs zero before the next edge; no timeout after release.

Source files
------------

// File: rtl/hdl_watchdog_timer.sv
// HDL-side watchdog for the truss interface: counts a loaded budget down in
// prescaled ticks and raises a sticky hdl_timeout_ when it runs out.
module hdl_watchdog_timer #(
    parameter int COUNTER_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [COUNTER_WIDTH-1:0]  hdl_timeout_count_,
    input  logic                      load,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      kick,
    input  logic                      clear,
    output logic                      hdl_timeout_,
    output logic                      armed,
    output logic [COUNTER_WIDTH-1:0]  remaining
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        EXPIRED
    } state_t;

    state_t                    state, state_nxt;
    logic [COUNTER_WIDTH-1:0]  budget, budget_nxt;
    logic [COUNTER_WIDTH-1:0]  remaining_nxt;
    logic [PRESCALE_WIDTH-1:0] pscale, pscale_nxt;
    logic [PRESCALE_WIDTH-1:0] pcnt, pcnt_nxt;
    logic                      timeout_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            budget       <= '0;
            pscale       <= '0;
            pcnt         <= '0;
            remaining    <= '0;
            hdl_timeout_ <= 1'b0;
        end else begin
            state        <= state_nxt;
            budget       <= budget_nxt;
            pscale       <= pscale_nxt;
            pcnt         <= pcnt_nxt;
            remaining    <= remaining_nxt;
            hdl_timeout_ <= timeout_nxt;
        end
    end

    // NOTE: every output of this block is given a hold default first, so no
    // path through the if/else chain can leave a variable unassigned (latch).
    always_comb begin
        state_nxt     = state;
        budget_nxt    = budget;
        pscale_nxt    = pscale;
        pcnt_nxt      = pcnt;
        remaining_nxt = remaining;
        timeout_nxt   = hdl_timeout_;

        // Strobe priority: load > clear > kick > tick.
        if (load) begin
            budget_nxt    = hdl_timeout_count_;
            pscale_nxt    = prescale;
            remaining_nxt = hdl_timeout_count_;
            pcnt_nxt      = prescale;
            timeout_nxt   = 1'b0;
            state_nxt     = (hdl_timeout_count_ != '0) ? ARMED : IDLE;
        end else if (clear) begin
            remaining_nxt = '0;
            timeout_nxt   = 1'b0;
            state_nxt     = IDLE;
        end else if (state == ARMED) begin
            if (kick) begin
                remaining_nxt = budget;
                pcnt_nxt      = pscale;
            end else if (pcnt != '0) begin
                pcnt_nxt = pcnt - PRESCALE_WIDTH'(1);
            end else begin
                pcnt_nxt = pscale;
                // A zero count here is treated as expiry so remaining never wraps.
                if (remaining <= COUNTER_WIDTH'(1)) begin
                    remaining_nxt = '0;
                    timeout_nxt   = 1'b1;
                    state_nxt     = EXPIRED;
                end else begin
                    remaining_nxt = remaining - COUNTER_WIDTH'(1);
                end
            end
        end
    end

    assign armed = (state == ARMED);

endmodule
